// File: rtl/rob_completion_arbiter_if.sv
// rtl/rob_completion_arbiter_if.sv - completion request/response bundle between execution units and the ROB arbiter
interface rob_completion_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ROB_ID_W  = 6,
    parameter int PKT_W     = 77
);
    logic [NUM_PORTS-1:0]       req_valid_i;
    logic [NUM_PORTS*PKT_W-1:0] req_pkt_i;
    logic [NUM_PORTS-1:0]       req_ready_o;
    logic                       flush_i;
    logic                       complete_valid_o;
    logic [ROB_ID_W-1:0]        complete_rob_id_o;
    logic [31:0]                complete_result_o;
    logic                       complete_exception_o;
    logic [3:0]                 complete_exc_cause_o;
    logic [31:0]                complete_br_target_o;
    logic                       complete_br_taken_o;
    logic                       complete_br_mispred_o;
    logic [NUM_PORTS-1:0]       pending_o;

    modport master (
        output req_valid_i, req_pkt_i, flush_i,
        input  req_ready_o, complete_valid_o, complete_rob_id_o, complete_result_o,
        input  complete_exception_o, complete_exc_cause_o, complete_br_target_o,
        input  complete_br_taken_o, complete_br_mispred_o, pending_o
    );

    modport slave (
        input  req_valid_i, req_pkt_i, flush_i,
        output req_ready_o, complete_valid_o, complete_rob_id_o, complete_result_o,
        output complete_exception_o, complete_exc_cause_o, complete_br_target_o,
        output complete_br_taken_o, complete_br_mispred_o, pending_o
    );
endinterface

// File: rtl/rob_completion_arbiter.sv
// rtl/rob_completion_arbiter.sv - round-robin arbiter sharing the ROB completion port between execution units
module rob_completion_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ROB_ID_W  = 6,
    parameter int PKT_W     = 77
) (
    input logic                    clk,
    input logic                    rst_n,
    rob_completion_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] buf_valid;
    logic [PKT_W-1:0]     buf_pkt [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] ready;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic                 grant_any;
    logic                 out_valid;
    logic [PKT_W-1:0]     out_pkt;

    // First occupied buffer at or above rr_ptr (wrapping) wins; flush masks every grant.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!bus.flush_i && !grant_any && buf_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    assign ready    = {NUM_PORTS{!bus.flush_i}} & (~buf_valid | grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_pkt   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                buf_pkt[i] <= '0;
            end
        end else if (bus.flush_i) begin
            buf_valid <= '0;
            out_valid <= 1'b0;
        end else begin
            // A refill in the grant cycle keeps the buffer occupied for full throughput.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.req_valid_i[i] && ready[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_pkt[i]   <= bus.req_pkt_i[i*PKT_W +: PKT_W];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            out_valid <= grant_any;
            if (grant_any) begin
                out_pkt <= buf_pkt[grant_idx];
                rr_ptr  <= next_ptr;
            end
        end
    end

    assign bus.req_ready_o           = ready;
    assign bus.pending_o             = buf_valid;
    assign bus.complete_valid_o      = out_valid;
    assign bus.complete_rob_id_o     = out_pkt[PKT_W-1 -: ROB_ID_W];
    assign bus.complete_result_o     = out_pkt[70:39];
    assign bus.complete_exception_o  = out_pkt[38];
    assign bus.complete_exc_cause_o  = out_pkt[37:34];
    assign bus.complete_br_target_o  = out_pkt[33:2];
    assign bus.complete_br_taken_o   = out_pkt[1];
    assign bus.complete_br_mispred_o = out_pkt[0];
endmodule
